// File: rtl/zap_ptw_arbiter_pkg.sv
// Shared types and constants for the page-table-walker bus arbiter.
// - arb_state_t : arbiter FSM states (IDLE / OWN / ABORT)
// - REQ_I/REQ_D : requester identifiers (instruction / data walker)
// - wb_req_t    : one walker's next-cycle Wishbone request bundle
package zap_ptw_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN   = 2'd1,
        ABORT = 2'd2
    } arb_state_t;

    localparam logic REQ_I = 1'b0;
    localparam logic REQ_D = 1'b1;

    typedef struct packed {
        logic        cyc;
        logic        stb;
        logic        wen;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] dat;
    } wb_req_t;

    localparam wb_req_t WB_REQ_NONE = '{cyc: 1'b0, stb: 1'b0, wen: 1'b0,
                                        sel: 4'h0, adr: 32'h0, dat: 32'h0};

    // One-hot grant vector for a requester id: bit0 = I, bit1 = D.
    function automatic logic [1:0] req_onehot(input logic id);
        logic [1:0] oh;
        if (id == REQ_D) begin
            oh = 2'b10;
        end else begin
            oh = 2'b01;
        end
        return oh;
    endfunction

endpackage

// File: rtl/zap_ptw_arbiter_wb_watchdog.sv
// Bus watchdog: counts consecutive stalled strobe cycles and fires when the
// count reaches TIMEOUT_CYCLES. TIMEOUT_CYCLES = 0 disables it entirely.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   clr        : clear the counter this cycle (idle, ack/err, or no strobe)
//   en         : a stalled strobe cycle is in progress
//   fire       : combinational, high on the cycle the limit is reached
module zap_wb_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 32'd256,
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 32'd0) ? 32'd1
                                                              : $clog2(TIMEOUT_CYCLES + 32'd1)
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic fire
);

    logic [CNT_W-1:0] cnt_r;

    generate
        if (TIMEOUT_CYCLES == 32'd0) begin : g_off
            assign fire = 1'b0;

            // Watchdog disabled: counter parked at zero.
            always_ff @(posedge clk) begin
                cnt_r <= {CNT_W{1'b0}};
            end
        end else begin : g_on
            localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 32'd1);
            localparam logic [CNT_W-1:0] ONE  = CNT_W'(32'd1);

            // The cycle on which the count would reach the limit is the firing cycle.
            assign fire = en & ~clr & (cnt_r == LAST);

            // Stall counter.
            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt_r <= {CNT_W{1'b0}};
                end else if (clr || fire) begin
                    cnt_r <= {CNT_W{1'b0}};
                end else if (en) begin
                    cnt_r <= cnt_r + ONE;
                end else begin
                    cnt_r <= cnt_r;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/zap_ptw_arbiter.sv
// Shares one Wishbone master port between the I-side and D-side page-table
// walkers. Each walker presents next-cycle (_nxt) request fields; the granted
// walker's fields are registered onto the shared bus with no added latency.
// Grants last for a whole walk (cyc high), round-robin between walkers, and a
// watchdog aborts walks whose strobe stalls too long.
// Ports:
//   i_clk, i_reset              : clock, synchronous active-high reset
//   i_i_wb_*_nxt / o_i_wb_*     : I-walker next-cycle request / ack, err, data
//   i_d_wb_*_nxt / o_d_wb_*     : D-walker next-cycle request / ack, err, data
//   o_wb_* / i_wb_*             : registered shared bus request / slave response
//   o_gnt                       : one-hot owner (bit0 = I, bit1 = D)
//   o_timeout                   : one-cycle pulse when the watchdog aborts a walk
module zap_ptw_arbiter
    import zap_ptw_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 32'd256
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_i_wb_cyc_nxt,
    input  logic        i_i_wb_stb_nxt,
    input  logic        i_i_wb_wen_nxt,
    input  logic [31:0] i_i_wb_adr_nxt,
    input  logic [3:0]  i_i_wb_sel_nxt,
    input  logic [31:0] i_i_wb_dat_nxt,
    output logic [31:0] o_i_wb_dat,
    output logic        o_i_wb_ack,
    output logic        o_i_wb_err,
    input  logic        i_d_wb_cyc_nxt,
    input  logic        i_d_wb_stb_nxt,
    input  logic        i_d_wb_wen_nxt,
    input  logic [31:0] i_d_wb_adr_nxt,
    input  logic [3:0]  i_d_wb_sel_nxt,
    input  logic [31:0] i_d_wb_dat_nxt,
    output logic [31:0] o_d_wb_dat,
    output logic        o_d_wb_ack,
    output logic        o_d_wb_err,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic        o_wb_wen,
    output logic [31:0] o_wb_adr,
    output logic [3:0]  o_wb_sel,
    output logic [31:0] o_wb_dat,
    input  logic [31:0] i_wb_dat,
    input  logic        i_wb_ack,
    input  logic        i_wb_err,
    output logic [1:0]  o_gnt,
    output logic        o_timeout
);

    arb_state_t state_r, state_nxt_s;
    wb_req_t    bus_r, bus_nxt_s;
    logic [1:0] gnt_r, gnt_nxt_s;
    logic       timeout_r, timeout_nxt_s;
    logic       owner_r, owner_nxt_s;
    logic       rr_last_r, rr_last_nxt_s;

    wb_req_t    i_req_s, d_req_s, own_req_s, win_req_s;
    logic       win_s;
    logic       ack_s, err_s, fire_s;
    logic       wd_clr_s, wd_en_s;

    assign i_req_s = '{cyc: i_i_wb_cyc_nxt, stb: i_i_wb_stb_nxt, wen: i_i_wb_wen_nxt,
                       sel: i_i_wb_sel_nxt, adr: i_i_wb_adr_nxt, dat: i_i_wb_dat_nxt};
    assign d_req_s = '{cyc: i_d_wb_cyc_nxt, stb: i_d_wb_stb_nxt, wen: i_d_wb_wen_nxt,
                       sel: i_d_wb_sel_nxt, adr: i_d_wb_adr_nxt, dat: i_d_wb_dat_nxt};

    // Owner request mux and round-robin winner selection for the idle state.
    always_comb begin
        own_req_s = i_req_s;
        win_s     = REQ_I;
        win_req_s = i_req_s;
        if (owner_r == REQ_D) begin
            own_req_s = d_req_s;
        end else begin
            own_req_s = i_req_s;
        end
        // On a tie the walker that did not own the bus last goes first.
        if (i_req_s.cyc && d_req_s.cyc) begin
            if (rr_last_r == REQ_I) begin
                win_s = REQ_D;
            end else begin
                win_s = REQ_I;
            end
        end else if (d_req_s.cyc) begin
            win_s = REQ_D;
        end else begin
            win_s = REQ_I;
        end
        if (win_s == REQ_D) begin
            win_req_s = d_req_s;
        end else begin
            win_req_s = i_req_s;
        end
    end

    // Bus responses only count while the owner's strobe is live in OWN.
    assign ack_s    = i_wb_ack & bus_r.cyc & bus_r.stb & (state_r == OWN);
    assign err_s    = i_wb_err & bus_r.cyc & bus_r.stb & (state_r == OWN);
    assign wd_clr_s = (state_r != OWN) | ~bus_r.stb | i_wb_ack | i_wb_err;
    assign wd_en_s  = (state_r == OWN) & bus_r.cyc & bus_r.stb & ~i_wb_ack & ~i_wb_err;

    zap_wb_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk   (i_clk),
        .reset (i_reset),
        .clr   (wd_clr_s),
        .en    (wd_en_s),
        .fire  (fire_s)
    );

    // Arbiter next-state and next registered bus outputs.
    always_comb begin
        state_nxt_s   = state_r;
        bus_nxt_s     = bus_r;
        gnt_nxt_s     = gnt_r;
        owner_nxt_s   = owner_r;
        rr_last_nxt_s = rr_last_r;
        timeout_nxt_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (i_req_s.cyc || d_req_s.cyc) begin
                    owner_nxt_s = win_s;
                    gnt_nxt_s   = req_onehot(win_s);
                    bus_nxt_s   = win_req_s;
                    state_nxt_s = OWN;
                end else begin
                    bus_nxt_s.cyc = 1'b0;
                    bus_nxt_s.stb = 1'b0;
                    gnt_nxt_s     = 2'b00;
                end
            end
            OWN: begin
                bus_nxt_s = own_req_s;
                if (fire_s) begin
                    bus_nxt_s.cyc = 1'b0;
                    bus_nxt_s.stb = 1'b0;
                    timeout_nxt_s = 1'b1;
                    state_nxt_s   = ABORT;
                end else if (!own_req_s.cyc) begin
                    bus_nxt_s.cyc = 1'b0;
                    bus_nxt_s.stb = 1'b0;
                    gnt_nxt_s     = 2'b00;
                    rr_last_nxt_s = owner_r;
                    state_nxt_s   = IDLE;
                end else begin
                    state_nxt_s = OWN;
                end
            end
            ABORT: begin
                // Bus stays quiet until the walker notices the error and drops cyc.
                bus_nxt_s.cyc = 1'b0;
                bus_nxt_s.stb = 1'b0;
                if (!own_req_s.cyc) begin
                    gnt_nxt_s     = 2'b00;
                    rr_last_nxt_s = owner_r;
                    state_nxt_s   = IDLE;
                end else begin
                    state_nxt_s = ABORT;
                end
            end
            default: begin
                bus_nxt_s.cyc = 1'b0;
                bus_nxt_s.stb = 1'b0;
                gnt_nxt_s     = 2'b00;
                state_nxt_s   = IDLE;
            end
        endcase
    end

    // Arbiter state and registered bus outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_r   <= IDLE;
            bus_r     <= WB_REQ_NONE;
            gnt_r     <= 2'b00;
            timeout_r <= 1'b0;
            owner_r   <= REQ_I;
            rr_last_r <= REQ_D;
        end else begin
            state_r   <= state_nxt_s;
            bus_r     <= bus_nxt_s;
            gnt_r     <= gnt_nxt_s;
            timeout_r <= timeout_nxt_s;
            owner_r   <= owner_nxt_s;
            rr_last_r <= rr_last_nxt_s;
        end
    end

    // Route bus responses to the current owner; the other walker sees zeros.
    always_comb begin
        o_i_wb_ack = 1'b0;
        o_i_wb_err = 1'b0;
        o_i_wb_dat = 32'h0;
        o_d_wb_ack = 1'b0;
        o_d_wb_err = 1'b0;
        o_d_wb_dat = 32'h0;
        if (state_r != IDLE) begin
            if (owner_r == REQ_D) begin
                o_d_wb_ack = ack_s;
                o_d_wb_err = err_s | fire_s;
                o_d_wb_dat = i_wb_dat;
            end else begin
                o_i_wb_ack = ack_s;
                o_i_wb_err = err_s | fire_s;
                o_i_wb_dat = i_wb_dat;
            end
        end else begin
            o_i_wb_ack = 1'b0;
            o_d_wb_ack = 1'b0;
        end
    end

    assign o_wb_cyc  = bus_r.cyc;
    assign o_wb_stb  = bus_r.stb;
    assign o_wb_wen  = bus_r.wen;
    assign o_wb_adr  = bus_r.adr;
    assign o_wb_sel  = bus_r.sel;
    assign o_wb_dat  = bus_r.dat;
    assign o_gnt     = gnt_r;
    assign o_timeout = timeout_r;

endmodule

// File: tb/tb_zap_ptw_arbiter.sv
// Scoreboard bench for zap_ptw_arbiter: stimulus pushes expected bus events
// (grant, walker response, watchdog pulse) with their cycle numbers; a monitor
// samples the DUT on the falling edge and compares each event it sees.
module tb_zap_ptw_arbiter;

    localparam int unsigned TO = 32'd4;

    localparam logic [1:0] EV_GNT = 2'd1;
    localparam logic [1:0] EV_RET = 2'd2;
    localparam logic [1:0] EV_TO  = 2'd3;

    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] cyc;
        logic [1:0]  gnt;
        logic [31:0] adr;
        logic [3:0]  ret;   // {i_ack, i_err, d_ack, d_err}
        logic [31:0] dat_i;
        logic [31:0] dat_d;
        logic        tcyc;
    } ev_t;

    logic        clk;
    logic        i_reset;
    logic        i_cyc, i_stb, i_wen, d_cyc, d_stb, d_wen;
    logic [31:0] i_adr, i_dat, d_adr, d_dat;
    logic [3:0]  i_sel, d_sel;
    logic [31:0] o_i_dat, o_d_dat;
    logic        o_i_ack, o_i_err, o_d_ack, o_d_err;
    logic        o_wb_cyc, o_wb_stb, o_wb_wen;
    logic [31:0] o_wb_adr, o_wb_dat;
    logic [3:0]  o_wb_sel;
    logic [31:0] wb_dat;
    logic        wb_ack, wb_err;
    logic [1:0]  o_gnt;
    logic        o_timeout;

    ev_t         exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int unsigned cyc_n    = 0;

    zap_ptw_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .i_clk(clk), .i_reset(i_reset),
        .i_i_wb_cyc_nxt(i_cyc), .i_i_wb_stb_nxt(i_stb), .i_i_wb_wen_nxt(i_wen),
        .i_i_wb_adr_nxt(i_adr), .i_i_wb_sel_nxt(i_sel), .i_i_wb_dat_nxt(i_dat),
        .o_i_wb_dat(o_i_dat), .o_i_wb_ack(o_i_ack), .o_i_wb_err(o_i_err),
        .i_d_wb_cyc_nxt(d_cyc), .i_d_wb_stb_nxt(d_stb), .i_d_wb_wen_nxt(d_wen),
        .i_d_wb_adr_nxt(d_adr), .i_d_wb_sel_nxt(d_sel), .i_d_wb_dat_nxt(d_dat),
        .o_d_wb_dat(o_d_dat), .o_d_wb_ack(o_d_ack), .o_d_wb_err(o_d_err),
        .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_wen(o_wb_wen),
        .o_wb_adr(o_wb_adr), .o_wb_sel(o_wb_sel), .o_wb_dat(o_wb_dat),
        .i_wb_dat(wb_dat), .i_wb_ack(wb_ack), .i_wb_err(wb_err),
        .o_gnt(o_gnt), .o_timeout(o_timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc_n++;
        end
    end

    function automatic ev_t ev_gnt(input logic [31:0] c, input logic [1:0] g, input logic [31:0] a);
        ev_t e;
        e = '0; e.kind = EV_GNT; e.cyc = c; e.gnt = g; e.adr = a;
        return e;
    endfunction

    function automatic ev_t ev_ret(input logic [31:0] c, input logic [3:0] r,
                                   input logic [31:0] di, input logic [31:0] dd);
        ev_t e;
        e = '0; e.kind = EV_RET; e.cyc = c; e.ret = r; e.dat_i = di; e.dat_d = dd;
        return e;
    endfunction

    function automatic ev_t ev_to(input logic [31:0] c, input logic tc);
        ev_t e;
        e = '0; e.kind = EV_TO; e.cyc = c; e.tcyc = tc;
        return e;
    endfunction

    function automatic logic [1:0] gbit(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

    function automatic logic [3:0] ackbits(input logic id);
        return id ? 4'b0010 : 4'b1000;
    endfunction

    task automatic check_ev(input ev_t got);
        ev_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event got kind=%0d cyc=%0d gnt=%b adr=%h ret=%b di=%h dd=%h tc=%b, required none",
                     got.kind, got.cyc, got.gnt, got.adr, got.ret, got.dat_i, got.dat_d, got.tcyc);
        end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
                n_fail++;
                $display("FAIL event got kind=%0d cyc=%0d gnt=%b adr=%h ret=%b di=%h dd=%h tc=%b, required kind=%0d cyc=%0d gnt=%b adr=%h ret=%b di=%h dd=%h tc=%b",
                         got.kind, got.cyc, got.gnt, got.adr, got.ret, got.dat_i, got.dat_d, got.tcyc,
                         e.kind, e.cyc, e.gnt, e.adr, e.ret, e.dat_i, e.dat_d, e.tcyc);
            end
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s got %h required %h", name, act, req);
        end
    endtask

    // Monitor: turns observed DUT activity into events for the scoreboard.
    initial begin
        logic prev_cyc;
        ev_t  g;
        prev_cyc = 1'b0;
        forever begin
            @(negedge clk);
            if (cyc_n > 0) begin
                if (o_wb_cyc && !prev_cyc) begin
                    g = '0; g.kind = EV_GNT; g.cyc = cyc_n; g.gnt = o_gnt; g.adr = o_wb_adr;
                    check_ev(g);
                end
                if (o_i_ack || o_i_err || o_d_ack || o_d_err) begin
                    g = '0; g.kind = EV_RET; g.cyc = cyc_n;
                    g.ret = {o_i_ack, o_i_err, o_d_ack, o_d_err};
                    g.dat_i = o_i_dat; g.dat_d = o_d_dat;
                    check_ev(g);
                end
                if (o_timeout) begin
                    g = '0; g.kind = EV_TO; g.cyc = cyc_n; g.tcyc = o_wb_cyc;
                    check_ev(g);
                end
            end
            prev_cyc = o_wb_cyc;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic id, input logic on, input logic [31:0] adr);
        if (id) begin
            d_cyc = on; d_stb = on; d_adr = adr; d_sel = 4'hF; d_wen = 1'b0; d_dat = 32'h0;
        end else begin
            i_cyc = on; i_stb = on; i_adr = adr; i_sel = 4'hF; i_wen = 1'b0; i_dat = 32'h0;
        end
    endtask

    // One walker alone: grant next edge, ack in the 2nd strobe cycle with cyc dropped.
    task automatic single_walk(input logic id, input logic [31:0] adr, input logic [31:0] rdat);
        set_req(id, 1'b1, adr);
        exp_q.push_back(ev_gnt(cyc_n + 1, gbit(id), adr));
        tick; tick;
        wb_ack = 1'b1; wb_dat = rdat; set_req(id, 1'b0, adr);
        exp_q.push_back(ev_ret(cyc_n, ackbits(id), id ? 32'h0 : rdat, id ? rdat : 32'h0));
        tick;
        wb_ack = 1'b0; wb_dat = 32'h0;
    endtask

    // Both walkers request together; expected winner given, loser follows after one idle cycle.
    task automatic pair_walk(input logic win, input logic [31:0] adr_w, input logic [31:0] adr_l,
                             input logic [31:0] rdat_w, input logic [31:0] rdat_l);
        logic lose;
        lose = ~win;
        set_req(win, 1'b1, adr_w);
        set_req(lose, 1'b1, adr_l);
        exp_q.push_back(ev_gnt(cyc_n + 1, gbit(win), adr_w));
        tick; tick;
        wb_ack = 1'b1; wb_dat = rdat_w; set_req(win, 1'b0, adr_w);
        exp_q.push_back(ev_ret(cyc_n, ackbits(win), win ? 32'h0 : rdat_w, win ? rdat_w : 32'h0));
        tick;
        wb_ack = 1'b0; wb_dat = 32'h0;
        exp_q.push_back(ev_gnt(cyc_n + 1, gbit(lose), adr_l));
        tick; tick;
        wb_ack = 1'b1; wb_dat = rdat_l; set_req(lose, 1'b0, adr_l);
        exp_q.push_back(ev_ret(cyc_n, ackbits(lose), lose ? 32'h0 : rdat_l, lose ? rdat_l : 32'h0));
        tick;
        wb_ack = 1'b0; wb_dat = 32'h0;
    endtask

    task automatic check_all_idle(input string tag);
        check_val({tag, "_cyc"}, {31'h0, o_wb_cyc}, 32'h0);
        check_val({tag, "_stb"}, {31'h0, o_wb_stb}, 32'h0);
        check_val({tag, "_adr"}, o_wb_adr, 32'h0);
        check_val({tag, "_gnt"}, {30'h0, o_gnt}, 32'h0);
        check_val({tag, "_timeout"}, {31'h0, o_timeout}, 32'h0);
        check_val({tag, "_ret"}, {28'h0, o_i_ack, o_i_err, o_d_ack, o_d_err}, 32'h0);
    endtask

    initial begin
        i_reset = 1'b1;
        wb_ack = 1'b0; wb_err = 1'b0; wb_dat = 32'h0;
        set_req(1'b0, 1'b0, 32'h0);
        set_req(1'b1, 1'b0, 32'h0);
        tick; tick;
        check_all_idle("reset");
        check_val("reset_sel", {28'h0, o_wb_sel}, 32'h0);
        check_val("reset_wdat", o_wb_dat, 32'h0);
        i_reset = 1'b0;

        // Simultaneous requests after reset, twice: I, D, I, D.
        pair_walk(1'b0, 32'h0000_0100, 32'h0000_0200, 32'h0101_0101, 32'h0202_0202);
        pair_walk(1'b0, 32'h0000_0300, 32'h0000_0400, 32'h0303_0303, 32'h0404_0404);

        // Single I walk; I owned last, so the next tie goes to D.
        single_walk(1'b0, 32'h0000_4000, 32'hA5A5_0001);
        pair_walk(1'b1, 32'h0000_0600, 32'h0000_0500, 32'h0606_0606, 32'h0505_0505);

        // D walk: beat 1 acked, beat 2 errors; grant held until D drops cyc while I waits.
        set_req(1'b1, 1'b1, 32'h0000_8000);
        exp_q.push_back(ev_gnt(cyc_n + 1, 2'b10, 32'h0000_8000));
        tick;
        wb_ack = 1'b1; wb_dat = 32'h1111_2222; set_req(1'b1, 1'b1, 32'h0000_8004);
        exp_q.push_back(ev_ret(cyc_n, 4'b0010, 32'h0, 32'h1111_2222));
        tick;
        wb_ack = 1'b0; wb_dat = 32'h0; set_req(1'b0, 1'b1, 32'h0000_1000);
        tick;
        wb_err = 1'b1;
        exp_q.push_back(ev_ret(cyc_n, 4'b0001, 32'h0, 32'h0));
        tick;
        wb_err = 1'b0; set_req(1'b1, 1'b0, 32'h0000_8004);
        tick;
        exp_q.push_back(ev_gnt(cyc_n + 1, 2'b01, 32'h0000_1000));
        tick; tick;
        wb_ack = 1'b1; wb_dat = 32'h3333_4444; set_req(1'b0, 1'b0, 32'h0000_1000);
        exp_q.push_back(ev_ret(cyc_n, 4'b1000, 32'h3333_4444, 32'h0));
        tick;
        wb_ack = 1'b0; wb_dat = 32'h0;

        // D walk that never gets acked: err on the 4th strobe cycle, then timeout pulse.
        set_req(1'b1, 1'b1, 32'h0000_C000);
        exp_q.push_back(ev_gnt(cyc_n + 1, 2'b10, 32'h0000_C000));
        tick; tick; tick; tick;
        exp_q.push_back(ev_ret(cyc_n, 4'b0001, 32'h0, 32'h0));
        tick;
        exp_q.push_back(ev_to(cyc_n, 1'b0));
        wb_ack = 1'b1; wb_dat = 32'hDEAD_BEEF;   // stray ack while aborting
        tick;
        wb_ack = 1'b0; wb_dat = 32'h0; set_req(1'b1, 1'b0, 32'h0000_C000);
        tick;

        // I owns last, then reset mid-walk; reset restores I priority on a tie.
        single_walk(1'b0, 32'h0000_7000, 32'h7777_0000);
        set_req(1'b0, 1'b1, 32'h0000_2000);
        exp_q.push_back(ev_gnt(cyc_n + 1, 2'b01, 32'h0000_2000));
        tick;
        i_reset = 1'b1; set_req(1'b0, 1'b0, 32'h0);
        tick;
        check_all_idle("midreset");
        i_reset = 1'b0;
        wb_ack = 1'b1;   // must not be forwarded from idle
        tick;
        wb_ack = 1'b0;
        pair_walk(1'b0, 32'h0000_2100, 32'h0000_2200, 32'h2121_2121, 32'h2222_2222);

        tick; tick;
        check_val("queue_empty", exp_q.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
